// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO registers for the E stage.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   rst      - asynchronous active-low reset
//   op       - operation (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO)
//   a, b     - forwarded rs / rt operands
//   hilo     - read select for out (0 = HI, 1 = LO)
//   stop     - exception abort of an in-flight or starting mult/div
//   restore  - exception undo of the last MTHI/MTLO
//   busy     - registered, high while a mult/div is in progress
//   out      - combinational read data (hilo ? lo : hi)
//   hi, lo   - current committed HI and LO
//
// The result of a mult/div is computed on the accept edge and parked in
// pending registers. HI/LO only change on the final busy edge, so a partial
// result is never visible and an abort simply drops the pending value.
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo,
    input  logic        stop,
    input  logic        restore,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Division on magnitudes so the INT_MIN / -1 case wraps to 0x80000000
    // cleanly. Returns {remainder, quotient}. A zero divisor is replaced by
    // one only to keep the arithmetic defined; that result is never committed.
    function automatic logic [63:0] div_calc(input logic sgn,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
        logic        neg_x;
        logic        neg_y;
        logic [31:0] mag_x;
        logic [31:0] mag_y;
        logic [31:0] q;
        logic [31:0] r;
        neg_x = sgn & x[31];
        neg_y = sgn & y[31];
        mag_x = neg_x ? (32'd0 - x) : x;
        mag_y = neg_y ? (32'd0 - y) : y;
        if (mag_y == 32'd0) begin
            mag_y = 32'd1;
        end else begin
            mag_y = mag_y;
        end
        q = mag_x / mag_y;
        r = mag_x % mag_y;
        if (neg_x ^ neg_y) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (neg_x) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    logic [31:0]      hi_r, lo_r, hi_n, lo_n;
    logic [31:0]      bk_hi_r, bk_lo_r, bk_hi_n, bk_lo_n;
    logic             bk_valid_r, bk_valid_n;
    logic [31:0]      pend_hi_r, pend_lo_r, pend_hi_n, pend_lo_n;
    logic             pend_wr_r, pend_wr_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             busy_r, busy_n;

    logic [63:0]      smul_s, umul_s, sdiv_s, udiv_s;
    logic             restore_s, accept_s;

    assign smul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign umul_s = {32'd0, a} * {32'd0, b};
    assign sdiv_s = div_calc(1'b1, a, b);
    assign udiv_s = div_calc(1'b0, a, b);

    // Next-state logic: restore, abort/countdown/commit, and op acceptance.
    always_comb begin
        hi_n       = hi_r;
        lo_n       = lo_r;
        bk_hi_n    = bk_hi_r;
        bk_lo_n    = bk_lo_r;
        bk_valid_n = bk_valid_r;
        pend_hi_n  = pend_hi_r;
        pend_lo_n  = pend_lo_r;
        pend_wr_n  = pend_wr_r;
        cnt_n      = cnt_r;
        restore_s  = restore & bk_valid_r;
        accept_s   = ~busy_r & ~stop & ~restore_s;

        if (restore_s) begin
            hi_n       = bk_hi_r;
            lo_n       = bk_lo_r;
            bk_valid_n = 1'b0;
        end else begin
            bk_valid_n = bk_valid_n;
        end

        if (busy_r) begin
            if (stop) begin
                cnt_n     = {CNT_W{1'b0}};
                pend_wr_n = 1'b0;
                pend_hi_n = 32'd0;
                pend_lo_n = 32'd0;
            end else if (cnt_r == CNT_W'(1)) begin
                // Commit overrides a same-edge restore for HI/LO.
                cnt_n      = {CNT_W{1'b0}};
                bk_valid_n = 1'b0;
                if (pend_wr_r) begin
                    hi_n = pend_hi_r;
                    lo_n = pend_lo_r;
                end else begin
                    hi_n = hi_n;
                end
            end else begin
                cnt_n = cnt_r - CNT_W'(1);
            end
        end else if (accept_s) begin
            case (op)
                OP_MULT: begin
                    {pend_hi_n, pend_lo_n} = smul_s;
                    pend_wr_n  = 1'b1;
                    cnt_n      = CNT_W'(MUL_CYCLES);
                    bk_valid_n = 1'b0;
                end
                OP_MULTU: begin
                    {pend_hi_n, pend_lo_n} = umul_s;
                    pend_wr_n  = 1'b1;
                    cnt_n      = CNT_W'(MUL_CYCLES);
                    bk_valid_n = 1'b0;
                end
                OP_DIV: begin
                    {pend_hi_n, pend_lo_n} = sdiv_s;
                    pend_wr_n  = (b != 32'd0);
                    cnt_n      = CNT_W'(DIV_CYCLES);
                    bk_valid_n = 1'b0;
                end
                OP_DIVU: begin
                    {pend_hi_n, pend_lo_n} = udiv_s;
                    pend_wr_n  = (b != 32'd0);
                    cnt_n      = CNT_W'(DIV_CYCLES);
                    bk_valid_n = 1'b0;
                end
                OP_MTHI: begin
                    bk_hi_n    = hi_r;
                    bk_lo_n    = lo_r;
                    bk_valid_n = 1'b1;
                    hi_n       = a;
                end
                OP_MTLO: begin
                    bk_hi_n    = hi_r;
                    bk_lo_n    = lo_r;
                    bk_valid_n = 1'b1;
                    lo_n       = a;
                end
                default: begin
                    cnt_n = cnt_n;
                end
            endcase
        end else begin
            cnt_n = cnt_n;
        end

        busy_n = (cnt_n != {CNT_W{1'b0}});
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            bk_hi_r    <= 32'd0;
            bk_lo_r    <= 32'd0;
            bk_valid_r <= 1'b0;
            pend_hi_r  <= 32'd0;
            pend_lo_r  <= 32'd0;
            pend_wr_r  <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            hi_r       <= hi_n;
            lo_r       <= lo_n;
            bk_hi_r    <= bk_hi_n;
            bk_lo_r    <= bk_lo_n;
            bk_valid_r <= bk_valid_n;
            pend_hi_r  <= pend_hi_n;
            pend_lo_r  <= pend_lo_n;
            pend_wr_r  <= pend_wr_n;
            cnt_r      <= cnt_n;
            busy_r     <= busy_n;
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
    assign out  = hilo ? lo_r : hi_r;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 5: number of busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10: number of busy cycles for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port op, input, 4 bits: operation from cw_e_md_op. Encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
REQ-006 The block SHALL have port a, input, 32 bits: forwarded rs operand from stage E.
REQ-007 The block SHALL have port b, input, 32 bits: forwarded rt operand from stage E.
REQ-008 The block SHALL have port hilo, input, 1 bit: read select; 0=HI, 1=LO.
REQ-009 The block SHALL have port stop, input, 1 bit: exception abort of the in-flight or starting mult/div.
REQ-010 The block SHALL have port restore, input, 1 bit: exception undo of the last MTHI/MTLO.
REQ-011 The block SHALL have port busy, output, 1 bit: mult/div in progress (drives e_md_busy).
REQ-012 The block SHALL have port out, output, 32 bits: read data for MFHI/MFLO.
REQ-013 The block SHALL have ports hi and lo, outputs, 32 bits each: current committed HI and LO.

Function
REQ-014 An op is accepted only on an edge where busy=0 and stop=0; in every other case it SHALL be ignored with no state change.
REQ-015 An accepted MULT SHALL take the signed 64-bit product a*b; MULTU SHALL take the unsigned product; the pending result SHALL be HI=product[63:32], LO=product[31:0].
REQ-016 An accepted DIV SHALL compute a signed quotient truncated toward zero into LO and a remainder with the sign of a into HI; DIVU SHALL compute the unsigned quotient and remainder.
REQ-017 For DIV with a=0x80000000 and b=0xFFFFFFFF, the block SHALL commit LO=0x80000000 and HI=0.
REQ-018 For DIV/DIVU with b=0, the block SHALL still go busy for DIV_CYCLES and SHALL leave HI and LO unchanged at completion.
REQ-019 On the accept edge, the block SHALL capture the pending result and load a cycle counter with MUL_CYCLES or DIV_CYCLES; busy SHALL be registered and equal to (counter != 0).
REQ-020 busy SHALL therefore be 0 in the accept cycle and 1 for exactly MUL_CYCLES or DIV_CYCLES following cycles.
REQ-021 On the edge where counter=1, the block SHALL write HI/LO from the pending result and clear the counter; new values SHALL be visible in the first cycle with busy=0.
REQ-022 While busy, HI and LO SHALL hold their pre-operation values, so no partial result is ever visible.
REQ-023 MTHI or MTLO, when accepted, SHALL first copy the current HI and LO into backup registers and set bk_valid=1, then write a to the selected register on the same edge.
REQ-024 MFHI, MFLO and NONE SHALL leave all state unchanged.
REQ-025 out SHALL be combinational: out = hilo ? lo : hi, independent of op.
REQ-026 stop=1 while busy SHALL clear the counter and discard the pending result on that edge; HI/LO keep their pre-operation values and busy=0 the next cycle.
REQ-027 stop=1 while idle SHALL have no effect beyond suppressing an op on the same edge.
REQ-028 restore=1 with bk_valid=1 SHALL load HI and LO from backup and clear bk_valid on that edge; restore takes precedence over any op on the same edge.
REQ-029 restore=1 with bk_valid=0 SHALL have no effect.
REQ-030 An accepted MULT/MULTU/DIV/DIVU SHALL clear bk_valid.
REQ-031 stop and restore asserted on the same edge SHALL both take effect.
REQ-032 At counter=1 with stop=0 and restore=1, the commit SHALL win over the backup for HI/LO, and bk_valid SHALL be cleared.

Reset
REQ-033 While rst=0, regardless of clock, the block SHALL drive HI, LO, pending result, backups and counter to 0, bk_valid=0 and busy=0; out therefore reads 0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no commit.
REQ-035 The first edge after rst rises SHALL accept an op normally.

Verification
REQ-036 MULT a=0xFFFFFFFE (-2), b=3 -> busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-037 DIV a=-7, b=2 -> busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 -> HI/LO unchanged after 10 busy cycles.
REQ-038 MTHI a=0x12345678 then restore=1 next cycle -> HI returns to its prior value and LO is untouched; a second restore has no effect.
REQ-039 DIV started, stop=1 in the 4th busy cycle -> busy=0 next cycle and HI/LO equal their pre-DIV values; op=MULT with stop=1 on the same edge -> never busy.
REQ-040 A new op presented while busy (MTLO a=5) -> ignored, and LO equals the mult/div result after completion.
REQ-041 rst pulled low mid-MULT without a clock edge -> busy, hi, lo and out are 0 immediately.
